// File: rtl/sdram_rr_arbiter.sv
// Round-robin Wishbone arbiter sharing one SDRAM slave port among NM masters.
// Optional build macro SDRAM_ARB_CPU_PRIO_EN: master 0 wins in IDLE and is exempt from MAX_BURST.
module sdram_rr_arbiter #(
    parameter int unsigned NM        = 4,
    parameter int unsigned MAX_BURST = 16,
    parameter int unsigned AW        = 32,
    parameter int unsigned DW        = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NM-1:0]      m_cyc_i,
    input  logic [NM-1:0]      m_stb_i,
    input  logic [NM-1:0]      m_we_i,
    input  logic [4*NM-1:0]    m_sel_i,
    input  logic [AW*NM-1:0]   m_adr_i,
    input  logic [DW*NM-1:0]   m_dat_i,
    output logic [NM-1:0]      m_ack_o,
    output logic [DW-1:0]      m_dat_o,
    output logic               s_cyc_o,
    output logic               s_stb_o,
    output logic               s_we_o,
    output logic [3:0]         s_sel_o,
    output logic [AW-1:0]      s_adr_o,
    output logic [DW-1:0]      s_dat_o,
    input  logic               s_ack_i,
    input  logic [DW-1:0]      s_dat_i,
    output logic [NM-1:0]      grant_o,
    output logic               busy_o
);

    localparam int unsigned LW = (NM > 1) ? $clog2(NM) : 1;
    localparam int unsigned BW = $clog2(MAX_BURST + 1);

`ifdef SDRAM_ARB_CPU_PRIO_EN
    localparam bit CpuPrio = 1'b1;
`else
    localparam bit CpuPrio = 1'b0;
`endif

    typedef enum logic [1:0] {StIdle, StGrant, StRelease} state_e;

    state_e          state_q, state_d;
    logic [NM-1:0]   grant_q, grant_d;
    logic [LW-1:0]   last_q, last_d;
    logic [BW-1:0]   beats_q, beats_d;
    logic [LW-1:0]   pick;
    logic            rr_found;
    logic            burst_end;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            grant_q <= '0;
            last_q  <= LW'(NM - 1);
            beats_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            beats_q <= beats_d;
        end
    end

    // First requester after last_q, wrapping; master 0 preempts the search in CPU-priority builds.
    always_comb begin
        pick     = last_q;
        rr_found = 1'b0;
        for (int unsigned i = 1; i <= NM; i++) begin
            if (!rr_found && m_cyc_i[LW'((32'(last_q) + i) % NM)]) begin
                pick     = LW'((32'(last_q) + i) % NM);
                rr_found = 1'b1;
            end
        end
        if (CpuPrio && m_cyc_i[0]) begin
            pick = '0;
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        beats_d   = beats_q;
        burst_end = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (|m_cyc_i) begin
                    state_d = StGrant;
                    grant_d = NM'(1) << pick;
                    last_d  = pick;
                    beats_d = '0;
                end
            end
            StGrant: begin
                if (s_ack_i && beats_q != BW'(MAX_BURST)) begin
                    beats_d = beats_q + BW'(1);
                end
                burst_end = s_ack_i && (beats_q + BW'(1) == BW'(MAX_BURST)) &&
                            !(CpuPrio && last_q == '0);
                if (!m_cyc_i[last_q] || burst_end) begin
                    state_d = StRelease;
                    grant_d = '0;
                end
            end
            StRelease: state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // last_q names the granted master for the whole of a GRANT tenure.
    always_comb begin
        m_ack_o = '0;
        m_dat_o = s_dat_i;
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_sel_o = '0;
        s_adr_o = '0;
        s_dat_o = '0;
        grant_o = grant_q;
        busy_o  = (state_q == StGrant);
        if (state_q == StGrant) begin
            for (int unsigned k = 0; k < NM; k++) begin
                if (last_q == LW'(k)) begin
                    s_cyc_o    = m_cyc_i[k];
                    s_stb_o    = m_stb_i[k];
                    s_we_o     = m_we_i[k];
                    s_sel_o    = m_sel_i[4*k +: 4];
                    s_adr_o    = m_adr_i[AW*k +: AW];
                    s_dat_o    = m_dat_i[DW*k +: DW];
                    m_ack_o[k] = s_ack_i;
                end
            end
        end
    end

endmodule
